// File: rtl/button_debounce.sv
// Three-channel pushbutton debouncer: synchronizer, debounce counter and press pulse per button.
// Optional auto-repeat on red and blue when BUTTON_REPEAT_EN is defined.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic       any_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [CNT_W-1:0] cnt_r [3];
    logic [CNT_W-1:0] cnt_s [3];
    logic [2:0]       level_s;
    logic [2:0]       press_s;

`ifdef BUTTON_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_r [2];
    logic [REP_W-1:0] rep_cnt_s [2];
    logic [1:0]       rep_phase_r;
    logic [1:0]       rep_phase_s;
`endif

    // Next-state: debounce counters, accepted level, press pulses and repeat timing
    always_comb begin
        level_s = btn_level;
        press_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cnt_s[i] = '0;
            if (sync2_r[i] == btn_level[i]) begin
                cnt_s[i] = '0;
            end else if (cnt_r[i] == CNT_LAST) begin
                level_s[i] = sync2_r[i];
                press_s[i] = sync2_r[i];
            end else begin
                cnt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
`ifdef BUTTON_REPEAT_EN
        // Only red (0) and blue (1) repeat; a falling level stops repeat on the same edge.
        for (int i = 0; i < 2; i++) begin
            rep_cnt_s[i]   = '0;
            rep_phase_s[i] = 1'b0;
            if (btn_level[i] && level_s[i]) begin
                if (rep_cnt_r[i] == (rep_phase_r[i] ? PERIOD_LAST : DELAY_LAST)) begin
                    press_s[i]     = 1'b1;
                    rep_cnt_s[i]   = '0;
                    rep_phase_s[i] = 1'b1;
                end else begin
                    rep_cnt_s[i]   = rep_cnt_r[i] + REP_W'(1);
                    rep_phase_s[i] = rep_phase_r[i];
                end
            end else begin
                rep_cnt_s[i]   = '0;
                rep_phase_s[i] = 1'b0;
            end
        end
`endif
    end

    // State register with asynchronous clear of every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 3'b000;
            sync2_r   <= 3'b000;
            btn_level <= 3'b000;
            btn_press <= 3'b000;
            any_press <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= '0;
            end
`ifdef BUTTON_REPEAT_EN
            for (int i = 0; i < 2; i++) begin
                rep_cnt_r[i] <= '0;
            end
            rep_phase_r <= 2'b00;
`endif
        end else begin
            sync1_r   <= btn_raw;
            sync2_r   <= sync1_r;
            btn_level <= level_s;
            btn_press <= press_s;
            any_press <= |press_s;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
`ifdef BUTTON_REPEAT_EN
            for (int i = 0; i < 2; i++) begin
                rep_cnt_r[i] <= rep_cnt_s[i];
            end
            rep_phase_r <= rep_phase_s;
`endif
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        logic [2:0] exp_p;

        rst_n   = 1'b0;
        btn_raw = 3'b000;
        tick(2);
        chk("reset_level", btn_level, 3'b000);
        chk("reset_press", btn_press, 3'b000);
        chk("reset_any", {2'b00, any_press}, 3'b000);
        rst_n = 1'b1;
        tick(3);
        chk("idle_level", btn_level, 3'b000);

        // Red steady high: level rises after the sixth edge counted from the first sampling edge
        btn_raw = 3'b001;
        tick(5);
        chk("red_early_level", btn_level, 3'b000);
        chk("red_early_press", btn_press, 3'b000);
        tick(1);
        chk("red_level", btn_level, 3'b001);
        chk("red_press", btn_press, 3'b001);
        chk("red_any", {2'b00, any_press}, 3'b001);
        tick(1);
        chk("red_press_1cyc", btn_press, 3'b000);
        chk("red_any_1cyc", {2'b00, any_press}, 3'b000);
        btn_raw = 3'b000;
        tick(5);
        chk("red_rel_hold", btn_level, 3'b001);
        chk("red_rel_nopress", btn_press, 3'b000);
        tick(1);
        chk("red_rel_level", btn_level, 3'b000);
        chk("red_rel_press", btn_press, 3'b000);

        // Blue glitch of 3 cycles is shorter than the debounce window
        btn_raw = 3'b010;
        for (int j = 0; j < 13; j++) begin
            if (j == 3) btn_raw = 3'b000;
            tick(1);
            chk("blue_glitch_level", btn_level, 3'b000);
            chk("blue_glitch_press", btn_press, 3'b000);
        end

        // Yellow bouncing every 2 cycles for 20 cycles, then steady high
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            btn_raw = (j % 2 == 0) ? 3'b100 : 3'b000;
            tick(1);
            if (btn_press != 3'b000) pulses++;
            tick(1);
            if (btn_press != 3'b000) pulses++;
        end
        chk("yel_bounce_level", btn_level, 3'b000);
        btn_raw = 3'b100;
        tick(5);
        if (btn_press != 3'b000) pulses++;
        chk("yel_before_press", btn_press, 3'b000);
        tick(1);
        chk("yel_press", btn_press, 3'b100);
        chk("yel_level", btn_level, 3'b100);
        if (btn_press != 3'b000) pulses++;
        for (int j = 0; j < 8; j++) begin
            tick(1);
            if (btn_press != 3'b000) pulses++;
        end
        chk("yel_pulse_count", 3'(pulses), 3'd1);
        btn_raw = 3'b000;
        tick(8);
        chk("yel_rel_level", btn_level, 3'b000);

        // Red and yellow rising together
        btn_raw = 3'b101;
        tick(6);
        chk("dual_press", btn_press, 3'b101);
        chk("dual_any", {2'b00, any_press}, 3'b001);
        tick(1);
        chk("dual_press_end", btn_press, 3'b000);
        btn_raw = 3'b000;
        tick(6);
        chk("dual_rel_level", btn_level, 3'b000);
        tick(2);

        // Reset mid-count with red still held
        btn_raw = 3'b001;
        tick(4);
        chk("rst_mid_level", btn_level, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("rst_async_level", btn_level, 3'b000);
        chk("rst_async_press", btn_press, 3'b000);
        tick(3);
        chk("rst_hold_level", btn_level, 3'b000);
        chk("rst_hold_any", {2'b00, any_press}, 3'b000);
        rst_n = 1'b1;
        tick(5);
        chk("rst_fresh_early", btn_press, 3'b000);
        tick(1);
        chk("rst_fresh_press", btn_press, 3'b001);
        btn_raw = 3'b000;
        tick(8);
        chk("rst_rel_level", btn_level, 3'b000);

        // Blue held for 30 cycles: repeat pulses only when auto-repeat is built in
        btn_raw = 3'b010;
        tick(6);
        chk("blue_hold_press", btn_press, 3'b010);
        for (int j = 1; j <= 36; j++) begin
            tick(1);
`ifdef BUTTON_REPEAT_EN
            exp_p = (j < 36 && j >= 10 && (j - 10) % 3 == 0) ? 3'b010 : 3'b000;
`else
            exp_p = 3'b000;
`endif
            chk("blue_repeat", btn_press, exp_p);
            if (j == 30) btn_raw = 3'b000;
        end
        chk("blue_rel_level", btn_level, 3'b000);
        tick(2);

        // Yellow held for 30 cycles never repeats
        btn_raw = 3'b100;
        tick(6);
        chk("yel_hold_press", btn_press, 3'b100);
        pulses = 0;
        for (int j = 1; j <= 36; j++) begin
            tick(1);
            if (btn_press != 3'b000) pulses++;
            if (j == 30) btn_raw = 3'b000;
        end
        chk("yel_norepeat", 3'(pulses), 3'd0);
        chk("yel_hold_rel", btn_level, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The module SHALL have the parameter DEBOUNCE_CYCLES, default 250000, meaning the consecutive cycles a new synchronized value must hold before it is accepted; legal values are >= 2.
REQ-002 The module SHALL have the parameter REPEAT_DELAY, default 25000000, meaning the cycles a button is held after its first press pulse before auto-repeat starts.
REQ-003 The module SHALL have the parameter REPEAT_PERIOD, default 5000000, meaning the cycles between auto-repeat pulses.
REQ-004 The module SHALL have the port clk  input  1  system clock; all logic is rising-edge.
REQ-005 The module SHALL have the port rst_n  input  1  reset; one clock, reset asynchronous, active-low.
REQ-006 The module SHALL have the port btn_raw  input  3  raw pushbuttons {yellow, blue, red}, asynchronous, active-high.
REQ-007 The module SHALL have the port btn_level  output  3  debounced level per button, same bit order; feeds the menu state machine button inputs.
REQ-008 The module SHALL have the port btn_press  output  3  one-cycle press pulse per button, same bit order.
REQ-009 The module SHALL have the port any_press  output  1  OR of btn_press, in the same cycle.

Function
REQ-010 Each bit SHALL pass through its own two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Each channel SHALL have its own counter, width $clog2(DEBOUNCE_CYCLES), that resets to 0 on every edge where sync2 == btn_level.
REQ-012 On an edge where sync2 != btn_level, if the counter == DEBOUNCE_CYCLES-1 the channel SHALL load btn_level <= sync2 and clear the counter; otherwise it SHALL increment the counter.
REQ-013 Latency: a raw change first sampled at edge k and held steady SHALL appear on btn_level after edge k+DEBOUNCE_CYCLES+1; press and release use the same latency.
REQ-014 A raw pulse or glitch whose synchronized width is < DEBOUNCE_CYCLES cycles SHALL leave btn_level and btn_press unchanged.
REQ-015 btn_press[i] SHALL be registered, high for exactly the one cycle in which btn_level[i] first reads 1 after a 0->1 transition; a release SHALL produce no pulse.
REQ-016 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses in the same cycle.
REQ-017 Bouncing during the counting window SHALL restart the count; no counter SHALL wrap past DEBOUNCE_CYCLES-1.

Reset
REQ-018 On rst_n low, sync1, sync2, btn_level, btn_press, any_press, all counters and all repeat state SHALL clear to 0 immediately, without waiting for clk.
REQ-019 If a button is held through reset release, the module SHALL debounce it as a fresh press (pulse after DEBOUNCE_CYCLES+1 edges).
REQ-020 A reset asserted mid-count or mid-repeat SHALL abort the count or repeat with no pulse emitted.

Configuration
REQ-021 With macro BUTTON_REPEAT_EN defined, red and blue SHALL auto-repeat; yellow (confirm) SHALL never repeat.
REQ-022 Auto-repeat behaviour: while the level stays high, an extra btn_press pulse SHALL occur REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles.
REQ-023 Release SHALL stop auto-repeat immediately and clear the repeat counter.
REQ-024 With BUTTON_REPEAT_EN undefined, the module SHALL emit exactly one pulse per press, SHALL ignore REPEAT_DELAY and REPEAT_PERIOD, and SHALL infer no repeat counters.

Verification
Scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-025 Stimulus: red steady high sampled at edge 0 -> red btn_level rises after edge 5; btn_press = 3'b001 for one cycle; any_press = 1 in that same cycle.
REQ-026 Stimulus: blue high for 3 cycles then low -> btn_level and btn_press stay 0 throughout.
REQ-027 Stimulus: yellow toggling every 2 cycles for 20 cycles, then steady high -> exactly one yellow pulse, 5 edges after the last toggle.
REQ-028 Stimulus: red and yellow rising on the same edge -> btn_press = 3'b101 in a single cycle.
REQ-029 Stimulus: rst_n pulled low mid-count (counter = 2), then released with the button still held -> outputs are 0 during reset; the pulse arrives 5 edges after the first post-reset sampling edge.
REQ-030 Stimulus: with BUTTON_REPEAT_EN defined, blue held for 30 cycles -> pulses at the initial cycle t, t+10, t+13, t+16, ...; yellow held the same way -> one pulse only. Without the macro -> one pulse for each button.
